// File: rtl/forest_pkg.sv
// Shared definitions for the random-forest vote aggregation blocks:
// default forest size, count-width helper and vote/count types.
package forest_pkg;

  localparam int DEF_NUM_TREES = 8;

  // Bits needed to hold a vote count of 0..n inclusive.
  function automatic int count_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Strict-majority threshold for an n-tree forest.
  function automatic int majority(input int n);
    return n / 2 + 1;
  endfunction

  localparam int DEF_CNT_W     = count_width(DEF_NUM_TREES);
  localparam int DEF_THRESHOLD = majority(DEF_NUM_TREES);

  typedef logic [DEF_NUM_TREES-1:0] vote_vec_t;
  typedef logic [DEF_CNT_W-1:0]     vote_count_t;

endpackage

// File: rtl/vote_popcount.sv
// Combinational balanced adder tree: counts the set bits of a vote vector.
// Shared by every forest aggregator that needs a raw vote count.
module vote_popcount
  import forest_pkg::*;
#(
  parameter int NUM_BITS = DEF_NUM_TREES,
  parameter int CNT_W    = count_width(NUM_BITS)
) (
  input  logic [NUM_BITS-1:0] votes,
  output logic [CNT_W-1:0]    count
);

  localparam int LEVELS = $clog2(NUM_BITS);
  localparam int LEAVES = 1 << LEVELS;

  always_comb begin
    logic [LEAVES-1:0] padded;
    logic [CNT_W-1:0]  part [LEAVES];
    // NOTE: every variable written in a combinational block gets a value on
    // every pass before any read, otherwise synthesis infers a latch.
    padded = LEAVES'(votes);
    for (int i = 0; i < LEAVES; i++) begin
      part[i] = CNT_W'(padded[i]);
    end
    // Pairwise reduction in place; each level halves the number of live sums.
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      for (int i = 0; i < (LEAVES >> (lvl + 1)); i++) begin
        part[i] = part[2*i] + part[2*i+1];
      end
    end
    count = part[0];
  end

endmodule

// File: rtl/forest_vote_accum.sv
// Forest vote accumulator: popcounts per-tree decisions in a 2-stage
// valid/ready pipeline, applies a majority threshold, keeps saturating stats.
module forest_vote_accum
  import forest_pkg::*;
#(
  parameter int NUM_TREES = DEF_NUM_TREES,
  parameter int THRESHOLD = majority(NUM_TREES),
  parameter int TAG_W     = 8,
  parameter int STAT_W    = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_TREES-1:0]              in_votes,
  input  logic [TAG_W-1:0]                  in_tag,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_class,
  output logic [count_width(NUM_TREES)-1:0] out_count,
  output logic [TAG_W-1:0]                  out_tag,
  input  logic                              stat_clear,
  output logic [STAT_W-1:0]                 stat_samples,
  output logic [STAT_W-1:0]                 stat_pos
);

  localparam int CNT_W = count_width(NUM_TREES);

  logic [CNT_W-1:0] vote_count;
  logic [CNT_W-1:0] s1_count;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_valid;
  logic             s1_class;
  logic             s2_valid;
  logic             adv1;
  logic             adv2;
  logic             accept;
  logic             handoff;

  vote_popcount #(
    .NUM_BITS (NUM_TREES),
    .CNT_W    (CNT_W)
  ) u_popcount (
    .votes (in_votes),
    .count (vote_count)
  );

  // Stage 2 advances when it is empty or draining; stage 1 whenever stage 2
  // makes room. in_ready depends only on state and out_ready, never in_valid.
  always_comb begin
    adv2 = s1_valid && (!s2_valid || out_ready);
    adv1 = !s1_valid || adv2;
  end

  assign in_ready  = adv1;
  assign accept    = in_valid && adv1;
  assign handoff   = s2_valid && out_ready;
  assign out_valid = s2_valid;
  assign s1_class  = (s1_count >= CNT_W'(THRESHOLD));

  // Payload registers load only on accept, so X on idle votes never enters.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of block order; the data registers are reset
    // as well because their values are visible on the output ports.
    if (rst) begin
      s1_valid <= 1'b0;
      s1_count <= '0;
      s1_tag   <= '0;
    end else begin
      if (adv1) begin
        s1_valid <= accept;
      end
      if (accept) begin
        s1_count <= vote_count;
        s1_tag   <= in_tag;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      out_class <= 1'b0;
      out_count <= '0;
      out_tag   <= '0;
    end else if (adv2) begin
      s2_valid  <= 1'b1;
      out_class <= s1_class;
      out_count <= s1_count;
      out_tag   <= s1_tag;
    end else if (handoff) begin
      s2_valid  <= 1'b0;
    end
  end

  // A clear coinciding with a handoff restarts the counts at that handoff.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_samples <= '0;
      stat_pos     <= '0;
    end else if (stat_clear) begin
      stat_samples <= STAT_W'(handoff);
      stat_pos     <= STAT_W'(handoff && out_class);
    end else if (handoff) begin
      if (stat_samples != '1) begin
        stat_samples <= stat_samples + STAT_W'(1);
      end
      if (out_class && (stat_pos != '1)) begin
        stat_pos <= stat_pos + STAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_forest_vote_accum.sv
// Self-checking bench for forest_vote_accum: directed steps, a scoreboard fed
// at accept time and drained at handoff, plus a narrow-stats instance.
module tb_forest_vote_accum;
  import forest_pkg::*;

  localparam int NT  = 8;
  localparam int THR = 5;
  localparam int TW  = 8;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [NT-1:0] in_votes;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic          out_class;
  logic [CW-1:0] out_count;
  logic [TW-1:0] out_tag;
  logic          stat_clear;
  logic [31:0]   stat_samples;
  logic [31:0]   stat_pos;

  logic          s_in_ready;
  logic          s_out_valid;
  logic          s_out_class;
  logic [CW-1:0] s_out_count;
  logic [TW-1:0] s_out_tag;
  logic [3:0]    s_stat_samples;
  logic [3:0]    s_stat_pos;

  always #5 clk = ~clk;

  forest_vote_accum dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_votes     (in_votes),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_class    (out_class),
    .out_count    (out_count),
    .out_tag      (out_tag),
    .stat_clear   (stat_clear),
    .stat_samples (stat_samples),
    .stat_pos     (stat_pos)
  );

  forest_vote_accum #(.STAT_W(4)) dut_sat (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (s_in_ready),
    .in_votes     (in_votes),
    .in_tag       (in_tag),
    .out_valid    (s_out_valid),
    .out_ready    (out_ready),
    .out_class    (s_out_class),
    .out_count    (s_out_count),
    .out_tag      (s_out_tag),
    .stat_clear   (stat_clear),
    .stat_samples (s_stat_samples),
    .stat_pos     (s_stat_pos)
  );

  typedef struct {
    logic          cls;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tag;
    int            acc;
  } exp_t;

  exp_t sb[$];
  int   hc[$];
  int   cyc = 0;
  int   last_lat = -1;
  int   checks = 0;
  int   failures = 0;
  exp_t mon_e;
  exp_t mon_p;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: away from the active edge, pop on handoff and push on accept.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          mon_p = sb.pop_front();
          check("sb_class", 64'(out_class), 64'(mon_p.cls));
          check("sb_count", 64'(out_count), 64'(mon_p.cnt));
          check("sb_tag", 64'(out_tag), 64'(mon_p.tag));
          last_lat = cyc - mon_p.acc;
          hc.push_back(cyc);
        end
      end
      if (in_valid && in_ready) begin
        mon_e.cnt = CW'($countones(in_votes));
        mon_e.cls = ($countones(in_votes) >= THR);
        mon_e.tag = in_tag;
        mon_e.acc = cyc;
        sb.push_back(mon_e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_votes = 'x;
    in_tag   = 'x;
  endtask

  task automatic send(input logic [NT-1:0] v, input logic [TW-1:0] t);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_votes = v;
    in_tag   = t;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    check("send_accept", 64'(ok), 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      step();
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_votes   = '0;
    in_tag     = '0;
    out_ready  = 1'b1;
    stat_clear = 1'b0;
    #12 rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_class", 64'(out_class), 64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_stat_samples", 64'(stat_samples), 64'd0);
    check("rst_stat_pos", 64'(stat_pos), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    step();

    // Single sample, exact 2-cycle latency.
    send(8'b1111_0001, 8'h3C);
    idle();
    check("t1_lat1_valid", 64'(out_valid), 64'd0);
    step();
    check("t1_out_valid", 64'(out_valid), 64'd1);
    check("t1_out_count", 64'(out_count), 64'd5);
    check("t1_out_class", 64'(out_class), 64'd1);
    check("t1_out_tag", 64'(out_tag), 64'h3C);
    check("t1_sat_tag", 64'(s_out_tag), 64'h3C);
    step();
    check("t1_stat_samples", 64'(stat_samples), 64'd1);
    check("t1_stat_pos", 64'(stat_pos), 64'd1);
    check("t1_valid_clear", 64'(out_valid), 64'd0);
    check("t1_latency", 64'(last_lat), 64'd2);

    // Threshold edges back to back.
    send(8'h00, 8'h10);
    send(8'h0F, 8'h11);
    send(8'h1F, 8'h12);
    send(8'hFF, 8'h13);
    idle();
    drain();
    check("t2_no_bubbles", 64'(hc[hc.size()-1] - hc[hc.size()-4]), 64'd3);
    check("t2_latency", 64'(last_lat), 64'd2);
    check("t2_stat_samples", 64'(stat_samples), 64'd5);
    check("t2_stat_pos", 64'(stat_pos), 64'd3);

    // Backpressure: two accepts fill the pipe, then everything holds.
    base = hc.size();
    out_ready = 1'b0;
    send(8'h01, 8'hA1);
    send(8'h7F, 8'hA2);
    in_valid = 1'b1;
    in_votes = 8'h3F;
    in_tag   = 8'hA3;
    for (int i = 0; i < 3; i++) begin
      check("t3_in_ready_low", 64'(in_ready), 64'd0);
      check("t3_hold_valid", 64'(out_valid), 64'd1);
      check("t3_hold_tag", 64'(out_tag), 64'hA1);
      check("t3_hold_count", 64'(out_count), 64'd1);
      check("t3_hold_class", 64'(out_class), 64'd0);
      step();
    end
    out_ready = 1'b1;
    send(8'h3F, 8'hA3);
    send(8'hFF, 8'hA4);
    idle();
    drain();
    check("t3_handoffs", 64'(hc.size() - base), 64'd4);
    check("t3_stat_samples", 64'(stat_samples), 64'd9);
    check("t3_stat_pos", 64'(stat_pos), 64'd6);

    // Clear colliding with a class-1 handoff, then a clear on its own.
    send(8'hFF, 8'h40);
    idle();
    step();
    check("t4_pre_valid", 64'(out_valid), 64'd1);
    stat_clear = 1'b1;
    step();
    stat_clear = 1'b0;
    check("t4_clr_samples", 64'(stat_samples), 64'd1);
    check("t4_clr_pos", 64'(stat_pos), 64'd1);
    stat_clear = 1'b1;
    step();
    stat_clear = 1'b0;
    check("t4_clr2_samples", 64'(stat_samples), 64'd0);
    check("t4_clr2_pos", 64'(stat_pos), 64'd0);
    check("t4_sat_clr_samples", 64'(s_stat_samples), 64'd0);

    // Saturation on the 4-bit statistics instance.
    for (int i = 0; i < 20; i++) send(8'h03, 8'(i));
    idle();
    drain();
    check("t5_samples", 64'(stat_samples), 64'd20);
    check("t5_pos", 64'(stat_pos), 64'd0);
    check("t5_sat_samples", 64'(s_stat_samples), 64'd15);
    check("t5_sat_pos", 64'(s_stat_pos), 64'd0);
    for (int i = 0; i < 20; i++) send(8'hF8, 8'(8'h80 + i));
    idle();
    drain();
    check("t5_samples2", 64'(stat_samples), 64'd40);
    check("t5_pos2", 64'(stat_pos), 64'd20);
    check("t5_sat_samples2", 64'(s_stat_samples), 64'd15);
    check("t5_sat_pos2", 64'(s_stat_pos), 64'd15);

    // Asynchronous reset with both stages full.
    out_ready = 1'b0;
    send(8'hFF, 8'h51);
    send(8'hFF, 8'h52);
    idle();
    check("t6_full_in_ready", 64'(in_ready), 64'd0);
    #3 rst = 1'b1;
    #1;
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_tag", 64'(out_tag), 64'd0);
    check("t6_rst_count", 64'(out_count), 64'd0);
    check("t6_rst_samples", 64'(stat_samples), 64'd0);
    check("t6_rst_pos", 64'(stat_pos), 64'd0);
    check("t6_rst_sat_samples", 64'(s_stat_samples), 64'd0);
    sb.delete();
    out_ready = 1'b1;
    #4 rst = 1'b0;
    step();
    send(8'h1F, 8'h61);
    idle();
    check("t6_lat1_valid", 64'(out_valid), 64'd0);
    step();
    check("t6_out_valid", 64'(out_valid), 64'd1);
    check("t6_out_tag", 64'(out_tag), 64'h61);
    drain();
    check("t6_latency", 64'(last_lat), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/forest_vote_accum.md
Name: forest_vote_accum

Overview:
- Downstream consumer of the per-tree classifier stages (one single-bit class1_treeN decision per tree).
- Collects the NUM_TREES tree decisions for one sample and popcounts them in a 2-stage pipeline.
- Applies a majority threshold and emits the forest's class decision with a valid/ready handshake.
- Keeps saturating sample and positive-decision counters for on-chip accuracy statistics.

Parameters:
NUM_TREES, 8, number of tree decision bits per sample (1..64)
THRESHOLD, 5, minimum vote count for class 1 (1..NUM_TREES)
TAG_W, 8, width of sample tag carried alongside votes
STAT_W, 32, width of statistics counters

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  vote vector valid
in_ready  output  1  block can accept vote vector
in_votes  input  NUM_TREES  bit k = decision of tree k
in_tag  input  TAG_W  sample identifier, passed through unchanged
out_valid  output  1  decision valid
out_ready  input  1  downstream accepts decision
out_class  output  1  1 when vote count >= THRESHOLD
out_count  output  CNT_W  vote count, CNT_W = clog2(NUM_TREES+1)
out_tag  output  TAG_W  tag of the sample being output
stat_clear  input  1  synchronous clear of statistics counters
stat_samples  output  STAT_W  decisions handed off since reset/clear
stat_pos  output  STAT_W  handed-off decisions with out_class=1

Behaviour:
- Reset (async assert, sync release): s1_valid=0, s2_valid=0, out_valid=0, out_class=0, out_count=0, out_tag=0, stat_samples=0, stat_pos=0. in_ready is 1 in the first cycle after reset deassertion.
- Input accept: a sample is accepted when in_valid && in_ready.
- Stage 1: on accept, register popcount(in_votes) into s1_count and in_tag into s1_tag; set s1_valid.
- Stage 2: register s1_count, s1_tag, and class = (s1_count >= THRESHOLD), compared unsigned at CNT_W bits. s2_valid drives out_valid.
- Tie rule: a count exactly equal to THRESHOLD gives class 1.
- Flow control:
  - adv2 = s1_valid && (!s2_valid || out_ready)
  - adv1 = !s1_valid || adv2
  - in_ready = adv1
  - in_ready is combinational from out_ready; there is no combinational path from in_valid to out_valid.
- Timing: latency is exactly 2 cycles from accept to out_valid when unstalled. Throughput is 1 sample/cycle with out_ready held high.
- Stall: when out_valid=1 and out_ready=0, out_class, out_count and out_tag hold stable. Stage 1 holds its sample. in_ready=0 once both stages are full. No sample is dropped or duplicated.
- Output handoff: on out_valid && out_ready with no new sample behind it, s2_valid clears next cycle. If stage 1 is valid, stage 1 moves into stage 2 in the same cycle.
- Statistics:
  - On each output handoff, stat_samples += 1, and stat_pos += 1 if out_class=1.
  - Both counters saturate at 2^STAT_W-1 (no wrap).
  - stat_clear=1: both counters reset next cycle. If a handoff happens in the same cycle, the counters load the values for that single handoff: stat_samples=1, stat_pos=out_class.
  - stat_clear does not affect the datapath.
- Reset mid-operation: all in-flight samples are discarded; outputs return to reset values immediately (async).
- in_votes values are don't-care while in_valid=0; an X on in_votes must not propagate into registers when not accepted.

Decomposition:
- Shared package forest_pkg:
  - NUM_TREES default
  - count-width function clog2(NUM_TREES+1)
  - vote-vector and count typedefs
  - default THRESHOLD = NUM_TREES/2+1
- Sub-module vote_popcount: a combinational adder tree of NUM_TREES bits to CNT_W bits, reused by other forest aggregators.

Test Plan:
- Reset then single sample: in_votes=8'b1111_0001 (5 votes), tag=0x3C, out_ready=1 -> 2 cycles after accept: out_valid=1, out_count=5, out_class=1, out_tag=0x3C; stat_samples=1, stat_pos=1.
- Threshold edges: votes 0x00, 0x0F (4), 0x1F (5), 0xFF (8) back-to-back -> class 0,0,1,1 and counts 0,4,5,8, one per cycle with no bubbles.
- Backpressure:
  - Stimulus: 4 samples with out_ready=0 for 5 cycles.
  - Response: in_ready drops after 2 accepts; outputs hold samples 1's values stable.
  - On release: samples 1..4 emerge in order with correct tags and none lost.
- Clear collision: stat_clear=1 in the same cycle as a class-1 handoff -> next cycle stat_samples=1, stat_pos=1. A clear with no handoff -> both 0.
- Saturation: with STAT_W=4, 20 class-0 handoffs -> stat_samples sticks at 15, stat_pos=0.
- Async reset mid-stream: rst asserted between clock edges while both stages are valid -> out_valid=0 immediately, counters 0. After release, the next sample has latency 2.
